// File: rtl/mii_frame_checker.sv
// mii_frame_checker
//   Multi-lane MII receive-side frame checker. Classifies every incoming word
//   (idle / start / data / terminate / error char), tracks the frame length
//   and reports one registered event per word: a good-frame pulse or an
//   error pulse with its class. Keeps saturating good-frame and error counters.
// Ports
//   clk          clock
//   i_rst        asynchronous reset, active-high
//   i_rx_data    8*LANES MII data, lane k = bits [8k+7:8k], lane 0 first
//   i_rx_ctrl    per-lane control flag (1 = control character)
//   i_clr_cnt    synchronous clear of o_frame_cnt / o_err_cnt
//   o_frame_ok   1-cycle pulse, frame closed with legal length
//   o_error      1-cycle pulse, protocol or length error
//   o_err_code   error class, valid with o_error (0 otherwise)
//   o_frame_len  byte count of the frame just closed / aborted in DATA
//   o_frame_cnt  good frames, saturating
//   o_err_cnt    error events, saturating
module mii_frame_checker #(
    parameter int LANES   = 8,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [8*LANES-1:0]   i_rx_data,
    input  logic [LANES-1:0]     i_rx_ctrl,
    input  logic                 i_clr_cnt,
    output logic                 o_frame_ok,
    output logic                 o_error,
    output logic [2:0]           o_err_code,
    output logic [LEN_W-1:0]     o_frame_len,
    output logic [CNT_W-1:0]     o_frame_cnt,
    output logic [CNT_W-1:0]     o_err_cnt
);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;

    localparam logic [2:0] E_BAD_IDLE  = 3'd1;
    localparam logic [2:0] E_BAD_START = 3'd2;
    localparam logic [2:0] E_BAD_TERM  = 3'd3;
    localparam logic [2:0] E_ERR_CHAR  = 3'd4;
    localparam logic [2:0] E_RUNT      = 3'd5;
    localparam logic [2:0] E_GIANT     = 3'd6;
    localparam logic [2:0] E_NO_TERM   = 3'd7;

    localparam logic [LEN_W-1:0] START_LEN = LEN_W'(LANES - 8);
    localparam logic [LEN_W-1:0] WORD_LEN  = LEN_W'(LANES);
    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = '1;

    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n, frame_len_n, close_len;
    logic             ok_n, err_n;
    logic [2:0]       code_n;

    logic             w_err, w_idle, w_data, w_start, w_fb, w_term, term_seen;
    logic [LEN_W-1:0] term_bytes;
    logic [7:0]       b;

    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] x,
                                                 input logic [LEN_W-1:0] y);
        logic [LEN_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[LEN_W] ? LEN_SAT : s[LEN_W-1:0];
    endfunction

    // Word classification, one pass over all lanes.
    always_comb begin
        w_err      = 1'b0;
        w_idle     = 1'b1;
        w_data     = 1'b1;
        w_fb       = 1'b0;
        w_start    = 1'b1;
        w_term     = 1'b0;
        term_seen  = 1'b0;
        term_bytes = '0;
        b          = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            b = i_rx_data[8*k +: 8];
            if (i_rx_ctrl[k] && b == C_ERR)    w_err  = 1'b1;
            if (!(i_rx_ctrl[k] && b == C_IDLE)) w_idle = 1'b0;
            if (i_rx_ctrl[k])                   w_data = 1'b0;
            if (i_rx_ctrl[k] && b == C_START)  w_fb   = 1'b1;
            if (k == 0) begin
                if (!(i_rx_ctrl[k] && b == C_START)) w_start = 1'b0;
            end else if (k < 7) begin
                if (i_rx_ctrl[k] || b != C_PRE) w_start = 1'b0;
            end else if (k == 7) begin
                if (i_rx_ctrl[k] || b != C_SFD) w_start = 1'b0;
            end else if (i_rx_ctrl[k]) begin
                w_start = 1'b0;
            end
            // Terminate: the first control lane must be TERM, all later lanes IDLE.
            if (!term_seen) begin
                if (i_rx_ctrl[k]) begin
                    term_seen  = 1'b1;
                    term_bytes = LEN_W'(k);
                    w_term     = (b == C_TERM);
                end
            end else if (!(i_rx_ctrl[k] && b == C_IDLE)) begin
                w_term = 1'b0;
            end
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len;
        frame_len_n = o_frame_len;
        ok_n        = 1'b0;
        err_n       = 1'b0;
        code_n      = '0;
        close_len   = sat_add(len, term_bytes);
        case (state)
            ST_IDLE: begin
                if (w_err) begin
                    err_n  = 1'b1;
                    code_n = E_ERR_CHAR;
                end else if (w_idle) begin
                    state_n = ST_IDLE;
                end else if (w_start) begin
                    state_n = ST_DATA;
                    len_n   = START_LEN;
                end else if (w_fb) begin
                    err_n  = 1'b1;
                    code_n = E_BAD_START;
                end else begin
                    err_n  = 1'b1;
                    code_n = E_BAD_IDLE;
                end
            end
            ST_DATA: begin
                if (w_err) begin
                    err_n       = 1'b1;
                    code_n      = E_ERR_CHAR;
                    frame_len_n = len;
                    state_n     = ST_IDLE;
                    len_n       = '0;
                end else if (w_data) begin
                    len_n = sat_add(len, WORD_LEN);
                end else if (w_term) begin
                    frame_len_n = close_len;
                    state_n     = ST_IDLE;
                    len_n       = '0;
                    if (close_len < MIN_L) begin
                        err_n  = 1'b1;
                        code_n = E_RUNT;
                    end else if (close_len > MAX_L || close_len == LEN_SAT) begin
                        err_n  = 1'b1;
                        code_n = E_GIANT;
                    end else begin
                        ok_n = 1'b1;
                    end
                end else if (w_start) begin
                    err_n       = 1'b1;
                    code_n      = E_NO_TERM;
                    frame_len_n = len;
                    len_n       = START_LEN;
                end else begin
                    err_n       = 1'b1;
                    code_n      = E_BAD_TERM;
                    frame_len_n = len;
                    state_n     = ST_IDLE;
                    len_n       = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                len_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            o_frame_ok  <= 1'b0;
            o_error     <= 1'b0;
            o_err_code  <= '0;
            o_frame_len <= '0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            o_frame_ok  <= ok_n;
            o_error     <= err_n;
            o_err_code  <= code_n;
            o_frame_len <= frame_len_n;
            // Counters count the registered pulses, so they step one cycle
            // after the pulse; a clear in the pulse cycle wins.
            if (i_clr_cnt)
                o_frame_cnt <= '0;
            else if (o_frame_ok && o_frame_cnt != '1)
                o_frame_cnt <= o_frame_cnt + 1'b1;
            if (i_clr_cnt)
                o_err_cnt <= '0;
            else if (o_error && o_err_cnt != '1)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

endmodule
